// File: rtl/sensor_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_pkg
// Description : Sensor frame layout, error codes, FSM states and field helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_frame_pkg;

   localparam int         FRAME_BYTES = 32;
   localparam int         FRAME_BITS  = FRAME_BYTES * 8;
   localparam logic [7:0] HEADER      = 8'hAA;

   localparam int OFS_HEADER   = 0;
   localparam int OFS_FLAGS    = 1;
   localparam int OFS_QUAT1    = 2;
   localparam int OFS_GYRO1    = 10;
   localparam int OFS_QUAT2    = 16;
   localparam int OFS_GYRO2    = 24;
   localparam int OFS_RESERVED = 30;
   localparam int OFS_CHECKSUM = 31;

   localparam int FLAG_QUAT1_VALID = 0;
   localparam int FLAG_GYRO1_VALID = 1;
   localparam int FLAG_QUAT2_VALID = 2;
   localparam int FLAG_GYRO2_VALID = 3;
   localparam int FLAG_CALIBRATE   = 4;
   localparam int FLAG_KICK        = 5;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_HEADER   = 2'd2;
   localparam logic [1:0] ERR_CHECKSUM = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_REL   = 3'd3,
      ST_CHK   = 3'd4
   } state_e;

   typedef struct packed {
      logic signed [15:0] w;
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } quat_t;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } gyro_t;

   typedef struct packed {
      quat_t      quat1;
      gyro_t      gyro1;
      quat_t      quat2;
      gyro_t      gyro2;
      logic [7:0] flags;
   } frame_fields_t;

   // Byte 0 sits in the top bits because the frame is shifted in MSB first.
   function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int idx);
      return f[FRAME_BITS-1-8*idx -: 8];
   endfunction

   function automatic logic [15:0] frame_word(input logic [FRAME_BITS-1:0] f, input int idx);
      return {frame_byte(f, idx), frame_byte(f, idx + 1)};
   endfunction

   function automatic logic [7:0] frame_xor(input logic [FRAME_BITS-1:0] f);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < OFS_CHECKSUM; i++) begin
         acc = acc ^ frame_byte(f, i);
      end
      return acc;
   endfunction

   function automatic frame_fields_t unpack_frame(input logic [FRAME_BITS-1:0] f);
      frame_fields_t r;
      r.quat1.w = frame_word(f, OFS_QUAT1 + 0);
      r.quat1.x = frame_word(f, OFS_QUAT1 + 2);
      r.quat1.y = frame_word(f, OFS_QUAT1 + 4);
      r.quat1.z = frame_word(f, OFS_QUAT1 + 6);
      r.gyro1.x = frame_word(f, OFS_GYRO1 + 0);
      r.gyro1.y = frame_word(f, OFS_GYRO1 + 2);
      r.gyro1.z = frame_word(f, OFS_GYRO1 + 4);
      r.quat2.w = frame_word(f, OFS_QUAT2 + 0);
      r.quat2.x = frame_word(f, OFS_QUAT2 + 2);
      r.quat2.y = frame_word(f, OFS_QUAT2 + 4);
      r.quat2.z = frame_word(f, OFS_QUAT2 + 6);
      r.gyro2.x = frame_word(f, OFS_GYRO2 + 0);
      r.gyro2.y = frame_word(f, OFS_GYRO2 + 2);
      r.gyro2.z = frame_word(f, OFS_GYRO2 + 4);
      r.flags   = frame_byte(f, OFS_FLAGS);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_frame_spi_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_spi_reader_if
// Description : load/done/sck/mosi/miso link between frame reader and slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_frame_spi_reader_if;
   logic load;
   logic done;
   logic sck;
   logic mosi;
   logic miso;

   modport master (output load, output sck, output mosi, input done, input miso);
   modport slave  (input load, input sck, input mosi, output done, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_mode0_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_mode0_rx_shifter
// Description : Mode-0 sck divider and 256-bit receive shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mode0_rx_shifter
   import sensor_frame_pkg::*;
#(
   parameter int SCK_HALF = 4
) (
   input  logic                  clk,
   input  logic                  fpga_rst_n,
   input  logic                  go,
   input  logic                  miso,
   output logic                  sck,
   output logic                  finished,
   output logic [FRAME_BITS-1:0] frame
);

   localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
   localparam logic [4:0] BYTE_LAST = 5'(FRAME_BYTES - 1);

   logic       active;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic [4:0] byte_cnt;
   logic       half_end;
   logic       last_bit;

   assign half_end = active && (div_cnt == HALF_LAST);
   assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == BYTE_LAST);
   // Asserted during the final high half so the FSM leaves SHIFT on the falling edge.
   assign finished = half_end && sck && last_bit;

   always_ff @(posedge clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         active   <= 1'b0;
         div_cnt  <= 8'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 5'd0;
         sck      <= 1'b0;
         frame    <= '0;
      end else if (go) begin
         active   <= 1'b1;
         div_cnt  <= 8'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 5'd0;
         sck      <= 1'b0;
      end else if (active) begin
         if (half_end) begin
            div_cnt <= 8'd0;
            if (!sck) begin
               sck <= 1'b1;
            end else begin
               // Sample on the last high cycle, just before the slave shifts on the fall.
               sck     <= 1'b0;
               frame   <= {frame[FRAME_BITS-2:0], miso};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_cnt <= byte_cnt + 5'd1;
               end
               if (last_bit) begin
                  active <= 1'b0;
               end
            end
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sensor_frame_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_spi_reader
// Description : Fetches, checks and unpacks the 32-byte sensor frame over SPI.
//               Define SENSOR_FRAME_CHECKSUM_EN to verify the B31 XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_spi_reader
   import sensor_frame_pkg::*;
#(
   parameter int SCK_HALF     = 4,
   parameter int DONE_TIMEOUT = 30000
) (
   input  logic                      clk,
   input  logic                      fpga_rst_n,
   input  logic                      start,
   output logic                      busy,
   sensor_frame_spi_reader_if.master spi,
   output logic signed [15:0]        quat1_w,
   output logic signed [15:0]        quat1_x,
   output logic signed [15:0]        quat1_y,
   output logic signed [15:0]        quat1_z,
   output logic signed [15:0]        quat2_w,
   output logic signed [15:0]        quat2_x,
   output logic signed [15:0]        quat2_y,
   output logic signed [15:0]        quat2_z,
   output logic signed [15:0]        gyro1_x,
   output logic signed [15:0]        gyro1_y,
   output logic signed [15:0]        gyro1_z,
   output logic signed [15:0]        gyro2_x,
   output logic signed [15:0]        gyro2_y,
   output logic signed [15:0]        gyro2_z,
   output logic [7:0]                flags,
   output logic                      frame_valid,
   output logic                      frame_error,
   output logic [1:0]                err_code
);

   localparam logic [2:0]  S_IDLE       = ST_IDLE;
   localparam logic [2:0]  S_REQ        = ST_REQ;
   localparam logic [2:0]  S_SHIFT      = ST_SHIFT;
   localparam logic [2:0]  S_REL        = ST_REL;
   localparam logic [2:0]  S_CHK        = ST_CHK;
   localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

   logic [2:0]            state;
   logic                  load_q;
   logic [15:0]           tcnt;
   logic                  done_meta;
   logic                  done_s;
   logic                  shift_go;
   logic                  shift_finished;
   logic                  sck_int;
   logic [FRAME_BITS-1:0] frame;
   logic                  hdr_ok;
   logic                  ck_ok;
   frame_fields_t         fields;

   always_ff @(posedge clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         done_meta <= 1'b0;
         done_s    <= 1'b0;
      end else begin
         done_meta <= spi.done;
         done_s    <= done_meta;
      end
   end

   assign shift_go = (state == S_REQ) && done_s;

   spi_mode0_rx_shifter #(
      .SCK_HALF (SCK_HALF)
   ) u_shifter (
      .clk        (clk),
      .fpga_rst_n (fpga_rst_n),
      .go         (shift_go),
      .miso       (spi.miso),
      .sck        (sck_int),
      .finished   (shift_finished),
      .frame      (frame)
   );

   assign hdr_ok = (frame_byte(frame, OFS_HEADER) == HEADER);
`ifdef SENSOR_FRAME_CHECKSUM_EN
   assign ck_ok  = (frame_xor(frame) == frame_byte(frame, OFS_CHECKSUM));
`else
   assign ck_ok  = 1'b1;
`endif

   always_ff @(posedge clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         state       <= S_IDLE;
         load_q      <= 1'b0;
         tcnt        <= 16'd0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         err_code    <= ERR_NONE;
         fields      <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // A slave still signalling done means the link is stuck; refuse the request.
                  if (done_s) begin
                     frame_error <= 1'b1;
                     err_code    <= ERR_TIMEOUT;
                  end else begin
                     state    <= S_REQ;
                     load_q   <= 1'b1;
                     tcnt     <= 16'd0;
                     err_code <= ERR_NONE;
                  end
               end
            end
            S_REQ: begin
               if (done_s) begin
                  state <= S_SHIFT;
               end else if (tcnt == TIMEOUT_LAST) begin
                  state       <= S_IDLE;
                  load_q      <= 1'b0;
                  frame_error <= 1'b1;
                  err_code    <= ERR_TIMEOUT;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            S_SHIFT: begin
               if (shift_finished) begin
                  state  <= S_REL;
                  load_q <= 1'b0;
                  tcnt   <= 16'd0;
               end
            end
            S_REL: begin
               if (!done_s) begin
                  state <= S_CHK;
               end else if (tcnt == TIMEOUT_LAST) begin
                  state       <= S_IDLE;
                  frame_error <= 1'b1;
                  err_code    <= ERR_TIMEOUT;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            S_CHK: begin
               state <= S_IDLE;
               if (!hdr_ok) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_HEADER;
               end else if (!ck_ok) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_CHECKSUM;
               end else begin
                  fields      <= unpack_frame(frame);
                  frame_valid <= 1'b1;
                  err_code    <= ERR_NONE;
               end
            end
            default: begin
               state  <= S_IDLE;
               load_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = (state != S_IDLE);
   assign spi.load = load_q;
   assign spi.sck  = sck_int;
   assign spi.mosi = 1'b0;

   assign quat1_w = fields.quat1.w;
   assign quat1_x = fields.quat1.x;
   assign quat1_y = fields.quat1.y;
   assign quat1_z = fields.quat1.z;
   assign quat2_w = fields.quat2.w;
   assign quat2_x = fields.quat2.x;
   assign quat2_y = fields.quat2.y;
   assign quat2_z = fields.quat2.z;
   assign gyro1_x = fields.gyro1.x;
   assign gyro1_y = fields.gyro1.y;
   assign gyro1_z = fields.gyro1.z;
   assign gyro2_x = fields.gyro2.x;
   assign gyro2_y = fields.gyro2.y;
   assign gyro2_z = fields.gyro2.z;
   assign flags   = fields.flags;

endmodule
`default_nettype wire

// File: tb/tb_sensor_frame_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_frame_spi_reader
// Description : Randomised frames from a behavioural slave, checked against a
//               byte-level reference model of the frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_frame_spi_reader;

   localparam int SCK_HALF     = 3;
   localparam int DONE_TIMEOUT = 300;
   localparam int TXN_BUDGET   = 4000;
`ifdef SENSOR_FRAME_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clk        = 1'b0;
   logic fpga_rst_n = 1'b0;
   logic start      = 1'b0;
   logic busy;
   logic signed [15:0] quat1_w, quat1_x, quat1_y, quat1_z;
   logic signed [15:0] quat2_w, quat2_x, quat2_y, quat2_z;
   logic signed [15:0] gyro1_x, gyro1_y, gyro1_z;
   logic signed [15:0] gyro2_x, gyro2_y, gyro2_z;
   logic [7:0]  flags;
   logic        frame_valid;
   logic        frame_error;
   logic [1:0]  err_code;

   sensor_frame_spi_reader_if spi_bus ();

   logic done_drv      = 1'b0;
   logic force_done    = 1'b0;
   logic miso_drv      = 1'b0;
   logic slave_respond = 1'b1;
   assign spi_bus.done = done_drv | force_done;
   assign spi_bus.miso = miso_drv;

   always #5 clk = ~clk;

   sensor_frame_spi_reader #(
      .SCK_HALF     (SCK_HALF),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) dut (
      .clk         (clk),
      .fpga_rst_n  (fpga_rst_n),
      .start       (start),
      .busy        (busy),
      .spi         (spi_bus),
      .quat1_w     (quat1_w),
      .quat1_x     (quat1_x),
      .quat1_y     (quat1_y),
      .quat1_z     (quat1_z),
      .quat2_w     (quat2_w),
      .quat2_x     (quat2_x),
      .quat2_y     (quat2_y),
      .quat2_z     (quat2_z),
      .gyro1_x     (gyro1_x),
      .gyro1_y     (gyro1_y),
      .gyro1_z     (gyro1_z),
      .gyro2_x     (gyro2_x),
      .gyro2_y     (gyro2_y),
      .gyro2_z     (gyro2_z),
      .flags       (flags),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .err_code    (err_code)
   );

   // Words in frame order: quat1 wxyz, gyro1 xyz, quat2 wxyz, gyro2 xyz.
   logic [15:0] obs [14];
   assign obs[0]  = quat1_w;  assign obs[1]  = quat1_x;
   assign obs[2]  = quat1_y;  assign obs[3]  = quat1_z;
   assign obs[4]  = gyro1_x;  assign obs[5]  = gyro1_y;
   assign obs[6]  = gyro1_z;  assign obs[7]  = quat2_w;
   assign obs[8]  = quat2_x;  assign obs[9]  = quat2_y;
   assign obs[10] = quat2_z;  assign obs[11] = gyro2_x;
   assign obs[12] = gyro2_y;  assign obs[13] = gyro2_z;

   logic [15:0]  exp_w [14];
   logic [7:0]   exp_flags;
   logic [15:0]  gen_w [14];
   logic [7:0]   gen_flags;
   logic [7:0]   frame_bytes [32];
   logic [255:0] cur_frame;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_compared++;
      if (obs_v !== exp_v) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs_v, exp_v);
      end
   endtask

   // Slave: raises done after a random delay, shifts on sck falls, releases after load drops.
   int   req_wait = 0;
   int   rel_wait = 0;
   logic sck_prev = 1'b0;
   logic [255:0] tx_sr = '0;
   always @(negedge clk) begin
      if (!done_drv) begin
         if (spi_bus.load && slave_respond) begin
            if (req_wait == 0) begin
               done_drv = 1'b1;
               tx_sr    = cur_frame;
               miso_drv = tx_sr[255];
               rel_wait = $urandom_range(0, 4);
            end else begin
               req_wait--;
            end
         end
      end else begin
         if (sck_prev && !spi_bus.sck) begin
            tx_sr    = {tx_sr[254:0], 1'b0};
            miso_drv = tx_sr[255];
         end
         if (!spi_bus.load) begin
            if (rel_wait == 0) begin
               done_drv = 1'b0;
               req_wait = $urandom_range(0, 6);
            end else begin
               rel_wait--;
            end
         end
      end
      sck_prev = spi_bus.sck;
   end

   task automatic random_fields();
      for (int i = 0; i < 14; i++) gen_w[i] = 16'($urandom);
      gen_flags = 8'($urandom_range(0, 63));
   endtask

   function automatic logic [7:0] xor_0_30();
      logic [7:0] x = 8'h00;
      for (int b = 0; b < 31; b++) x = x ^ frame_bytes[b];
      return x;
   endfunction

   task automatic build_frame(input logic [7:0] hdr, input logic [7:0] ck_flip);
      frame_bytes[0] = hdr;
      frame_bytes[1] = gen_flags;
      for (int i = 0; i < 14; i++) begin
         frame_bytes[2 + 2*i] = gen_w[i][15:8];
         frame_bytes[3 + 2*i] = gen_w[i][7:0];
      end
      frame_bytes[30] = 8'($urandom);
      frame_bytes[31] = xor_0_30() ^ ck_flip;
      for (int b = 0; b < 32; b++) cur_frame[255 - 8*b -: 8] = frame_bytes[b];
   endtask

   function automatic int model_err();
      if (frame_bytes[0] != 8'hAA) return 2;
      if (CK_EN && (xor_0_30() != frame_bytes[31])) return 3;
      return 0;
   endfunction

   task automatic check_fields(input string tag);
      for (int i = 0; i < 14; i++)
         check_val($sformatf("%s_word%0d", tag, i), {16'h0, obs[i]}, {16'h0, exp_w[i]});
      check_val({tag, "_flags"}, {24'h0, flags}, {24'h0, exp_flags});
   endtask

   task automatic do_txn(input string tag, input bit extra_start);
      int   exp_err = model_err();
      int   fv = 0, fe = 0, rises = 0, done_at = -1;
      logic busy_at = 1'b1;
      logic load_prev = 1'b0;
      start = 1'b1;
      for (int c = 0; c < TXN_BUDGET; c++) begin
         @(negedge clk);
         start = extra_start && (c == 20);
         if (spi_bus.load && !load_prev) rises++;
         load_prev = spi_bus.load;
         if (frame_valid) fv++;
         if (frame_error) fe++;
         if ((frame_valid || frame_error) && done_at < 0) begin
            done_at = c;
            busy_at = busy;
         end
         if (done_at >= 0 && c >= done_at + 5) break;
      end
      start = 1'b0;
      check_val({tag, "_completed"}, {31'h0, (done_at >= 0)}, 32'd1);
      check_val({tag, "_valid_pulses"}, fv, (exp_err == 0) ? 1 : 0);
      check_val({tag, "_error_pulses"}, fe, (exp_err == 0) ? 0 : 1);
      check_val({tag, "_err_code"}, {30'h0, err_code}, exp_err);
      check_val({tag, "_busy_at_pulse"}, {31'h0, busy_at}, 32'd0);
      check_val({tag, "_load_rises"}, rises, 1);
      check_val({tag, "_busy_after"}, {31'h0, busy}, 32'd0);
      if (exp_err == 0) begin
         for (int i = 0; i < 14; i++) exp_w[i] = gen_w[i];
         exp_flags = gen_flags;
      end
      check_fields(tag);
   endtask

   initial begin
      int n_cnt;
      int load_hi;
      logic sck_seen;
      logic [7:0] h;

      for (int i = 0; i < 14; i++) exp_w[i] = 16'h0;
      exp_flags = 8'h00;

      repeat (3) @(negedge clk);
      check_val("rst_load", {31'h0, spi_bus.load}, 32'd0);
      check_val("rst_sck", {31'h0, spi_bus.sck}, 32'd0);
      check_val("rst_mosi", {31'h0, spi_bus.mosi}, 32'd0);
      check_val("rst_busy", {31'h0, busy}, 32'd0);
      check_val("rst_valid_error", {30'h0, frame_valid, frame_error}, 32'd0);
      check_val("rst_err_code", {30'h0, err_code}, 32'd0);
      check_fields("rst");
      fpga_rst_n = 1'b1;
      repeat (3) @(negedge clk);

      random_fields();
      gen_w[0]  = 16'h1234;
      gen_w[13] = 16'hFF80;
      gen_flags = 8'h3F;
      build_frame(8'hAA, 8'h00);
      do_txn("directed_good", 1'b0);
      check_val("quat1_w_value", {16'h0, quat1_w}, 32'h1234);
      check_val("gyro2_z_neg128", $signed(gyro2_z), -128);
      check_val("flags_value", {24'h0, flags}, 32'h3F);

      build_frame(8'h55, 8'h00);
      do_txn("bad_header", 1'b0);

      random_fields();
      build_frame(8'hAA, 8'h5A);
      do_txn("bad_checksum", 1'b0);

      // done never rises: load must stay up for exactly DONE_TIMEOUT cycles.
      slave_respond = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      load_hi = 0;
      n_cnt   = 0;
      for (int c = 0; c < DONE_TIMEOUT + 20; c++) begin
         if (spi_bus.load) load_hi++;
         if (frame_error) n_cnt++;
         @(negedge clk);
      end
      check_val("timeout_load_cycles", load_hi, DONE_TIMEOUT);
      check_val("timeout_error_pulses", n_cnt, 1);
      check_val("timeout_err_code", {30'h0, err_code}, 32'd1);
      check_val("timeout_busy", {31'h0, busy}, 32'd0);
      check_fields("timeout");
      slave_respond = 1'b1;
      repeat (3) @(negedge clk);

      // done already high at start: immediate error, no load.
      force_done = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      load_hi = 0;
      n_cnt   = 0;
      for (int c = 0; c < 10; c++) begin
         if (spi_bus.load || busy) load_hi++;
         if (frame_error) n_cnt++;
         @(negedge clk);
      end
      check_val("stuck_done_error_pulses", n_cnt, 1);
      check_val("stuck_done_load_busy", load_hi, 0);
      check_val("stuck_done_err_code", {30'h0, err_code}, 32'd1);
      force_done = 1'b0;
      repeat (4) @(negedge clk);

      random_fields();
      build_frame(8'hAA, 8'h00);
      do_txn("double_start", 1'b1);

      for (int k = 0; k < 6; k++) begin
         random_fields();
         case ($urandom_range(0, 3))
            0, 1: build_frame(8'hAA, 8'h00);
            2: begin
               h = 8'($urandom);
               if (h == 8'hAA) h = 8'h00;
               build_frame(h, 8'h00);
            end
            default: build_frame(8'hAA, 8'($urandom_range(1, 255)));
         endcase
         do_txn($sformatf("rand%0d", k), 1'b0);
      end

      // Reset in the middle of the shift, at the 100th sck rise.
      random_fields();
      build_frame(8'hAA, 8'h00);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      n_cnt    = 0;
      sck_seen = 1'b0;
      for (int c = 0; c < TXN_BUDGET; c++) begin
         @(negedge clk);
         if (spi_bus.sck && !sck_seen) n_cnt++;
         sck_seen = spi_bus.sck;
         if (n_cnt == 100) break;
      end
      check_val("reach_bit100", n_cnt, 100);
      #2 fpga_rst_n = 1'b0;
      #1;
      check_val("midrst_load", {31'h0, spi_bus.load}, 32'd0);
      check_val("midrst_sck", {31'h0, spi_bus.sck}, 32'd0);
      check_val("midrst_busy", {31'h0, busy}, 32'd0);
      for (int i = 0; i < 14; i++) exp_w[i] = 16'h0;
      exp_flags = 8'h00;
      check_fields("midrst");
      repeat (3) @(negedge clk);
      fpga_rst_n = 1'b1;
      n_cnt = 0;
      for (int c = 0; c < 100 && spi_bus.done; c++) begin
         @(negedge clk);
         n_cnt++;
      end
      check_val("midrst_done_released", {31'h0, spi_bus.done}, 32'd0);
      repeat (5) @(negedge clk);
      random_fields();
      build_frame(8'hAA, 8'h00);
      do_txn("after_rst", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sensor_frame_spi_reader.md
# sensor_frame_spi_reader

SPI master that fetches the 32-byte sensor frame from `sensor_data_spi_slave` over the load/done/sck/sdo link, then checks and unpacks it into quaternion, gyro and button fields. It is the MCU end of that link built in fabric, for hardware loopback self-test and for a second FPGA consuming the frame stream.

## Interface
Parameters:
- `SCK_HALF`, default 4: clk cycles per sck half-period; legal range 2..255.
- `DONE_TIMEOUT`, default 30000: clk cycles allowed for each done edge; 16-bit counter.

Ports:
- `clk`  in  1  system clock.
- `fpga_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle frame request.
- `busy`  out  1  high from accepted start until return to IDLE.
- `load`  out  1  frame request to slave.
- `done`  in  1  slave frame-ready; asynchronous, 2-FF synchronised.
- `sck`  out  1  SPI clock, mode 0.
- `mosi`  out  1  tied 0.
- `miso`  in  1  slave data, MSB first.
- `quat1_w/x/y/z`, `quat2_w/x/y/z`  out  16 signed each  quaternions.
- `gyro1_x/y/z`, `gyro2_x/y/z`  out  16 signed each  gyro rates.
- `flags`  out  8  frame flag byte.
- `frame_valid`  out  1  one-cycle pulse when a good frame is latched.
- `frame_error`  out  1  one-cycle pulse on a failed transaction.
- `err_code`  out  2  0 none, 1 timeout, 2 header, 3 checksum; held until next start.

## Operation
- Frame layout, bytes MSB first:
  - B0: header 0xAA.
  - B1: flags. bit0 quat1_valid, bit1 gyro1_valid, bit2 quat2_valid, bit3 gyro2_valid, bit4 calibrate, bit5 kick.
  - B2–9: quat1 w,x,y,z.
  - B10–15: gyro1 x,y,z.
  - B16–23: quat2.
  - B24–29: gyro2.
  - B30: reserved.
  - B31: checksum, XOR of B0–B30.
- States:
  - IDLE: load=0, sck=0. Accepts `start` only if done_s=0. A start with done_s=1 pulses frame_error with err_code=1 and does no transfer.
  - REQ: load=1. Waits for done_s=1, then goes to SHIFT.
  - SHIFT: clocks 256 bits.
  - REL: load=0. Waits for done_s=0.
  - CHK: one cycle. Validates the frame and updates the outputs.
- `start` is ignored while busy. Inputs are held during a transfer.
- The 256-bit shift register is 32 bytes. A byte counter wraps 31→0 on the last bit, which ends SHIFT.
- Timeout counter:
  - Cleared on entry to REQ and to REL.
  - Reaching DONE_TIMEOUT in either state forces load=0 and goes to IDLE, pulsing frame_error with err_code=1.
- CHK priority order:
  - Header mismatch → err 2.
  - Else checksum mismatch → err 3.
  - Else fields latched, frame_valid pulses, err_code=0.
- Output fields change only in CHK on a good frame. On error they keep the last good frame.
- Field decode: signed 16-bit, {high byte, low byte}. No arithmetic is performed.

## Timing
- Reset values:
  - load=0, sck=0, mosi=0, busy=0.
  - All fields 0, flags 0.
  - frame_valid=0, frame_error=0, err_code=0.
  - State IDLE.
- done_s lags done by 2 clk cycles.
- First sck rise occurs SCK_HALF cycles after SHIFT entry.
- Each bit is SCK_HALF cycles low, then SCK_HALF cycles high.
- miso is sampled on the last clk cycle of the sck high phase, i.e. just before the falling edge on which the slave shifts.
- sck returns low after bit 255 and stays low outside SHIFT.
- REL is entered on the cycle after the final falling edge.
- Good-frame latency:
  - From the cycle REL observes done_s=0 to frame_valid is 2 cycles (REL→CHK→IDLE; pulse registered).
  - busy drops together with frame_valid.
- Reset mid-transfer: asynchronous return to reset values. load drops immediately and the slave sees an aborted transaction.

## Configuration
- `SENSOR_FRAME_CHECKSUM_EN`
  - Defined: B31 is verified as described; mismatch → err 3.
  - Undefined: B31 is ignored, only the header is checked, and err_code 3 is never produced.

## Structure
- Package `sensor_frame_pkg`:
  - Frame length 32, HEADER 8'hAA.
  - Byte offsets for each field, flag bit indices.
  - err_code localparams, state enum typedef.
  - Shared with `sensor_data_packer` so both ends agree on the layout.
- One sub-module, `spi_mode0_rx_shifter`:
  - Owns the sck divider, bit/byte counters and the shift register.
  - start/finished handshake with the FSM.

## Test plan
- Slave model serves a frame with B0=0xAA, quat1_w bytes 0x12 0x34, gyro2_z bytes 0xFF 0x80, flags 0x3F, valid XOR → quat1_w=16'sh1234, gyro2_z=-128, flags=0x3F, one frame_valid pulse, err_code=0.
- Same frame with B0=0x55 → frame_error, err_code=2, fields unchanged from the previous good frame.
- B31 corrupted → err_code=3 with the macro defined. Without the macro: frame_valid.
- done never rises after start → load falls after exactly DONE_TIMEOUT cycles in REQ, err_code=1, busy=0.
- done held high before start → immediate frame_error, err_code=1, load never asserts. A second start during busy is ignored.
- fpga_rst_n pulsed at bit 100 → load=0, sck=0, busy=0 immediately. The next start completes a good frame.
